// File: rtl/dds_pkg.sv
// Shared constants, loader state encoding and load-target encoding for the DDS phase accumulator.
package dds_pkg;

    localparam int ACC_W_DEF   = 24;
    localparam int PHASE_W_DEF = 14;
    localparam int FTW_BYTES   = 3;
    localparam int POFF_BYTES  = 2;
    localparam int SHADOW_W    = 8 * FTW_BYTES;

    typedef enum logic [1:0] {
        LD_IDLE   = 2'd0,
        LD_BYTE   = 2'd1,
        LD_COMMIT = 2'd2
    } load_state_t;

    typedef enum logic {
        TGT_FTW  = 1'b0,
        TGT_POFF = 1'b1
    } load_tgt_t;

    function automatic logic [1:0] bytes_for(input load_tgt_t tgt);
        return (tgt == TGT_POFF) ? 2'(POFF_BYTES) : 2'(FTW_BYTES);
    endfunction

endpackage

// File: rtl/dds_byte_loader.sv
// Byte-serial loader: collects MSB-first bytes into a shadow register and presents one COMMIT cycle.
module dds_byte_loader
    import dds_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [7:0]          load_data,
    input  logic                load_tgt,
    input  logic                load_abort,
    output logic [SHADOW_W-1:0] shadow,
    output load_tgt_t           tgt,
    output load_state_t         state
);

    // Handshake: a byte moves only on a rising edge where load_valid and load_ready are both 1;
    // load_ready never depends on load_valid.
    load_state_t state_q, state_d;
    load_tgt_t   tgt_q, tgt_d, tgt_eff;
    logic [1:0]  cnt_q, cnt_d;
    logic        armed_q;
    logic        xfer;
    logic        last;

    // armed_q holds load_ready low through reset and releases it on the first clock afterwards.
    assign load_ready = armed_q && (state_q != LD_COMMIT);
    assign xfer       = load_valid && load_ready;
    assign tgt_eff    = (state_q == LD_IDLE) ? load_tgt_t'(load_tgt) : tgt_q;
    assign last       = ((cnt_q + 2'd1) == bytes_for(tgt_eff));
    assign tgt        = tgt_q;
    assign state      = state_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        case (state_q)
            LD_IDLE: begin
                if (!load_abort && xfer) begin
                    state_d = last ? LD_COMMIT : LD_BYTE;
                    cnt_d   = 2'd1;
                    tgt_d   = tgt_eff;
                end
            end
            LD_BYTE: begin
                if (load_abort) begin
                    state_d = LD_IDLE;
                    cnt_d   = 2'd0;
                end else if (xfer) begin
                    cnt_d = cnt_q + 2'd1;
                    if (last) begin
                        state_d = LD_COMMIT;
                    end
                end
            end
            LD_COMMIT: begin
                state_d = LD_IDLE;
                cnt_d   = 2'd0;
            end
            default: begin
                state_d = LD_IDLE;
                cnt_d   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LD_IDLE;
            cnt_q   <= 2'd0;
            tgt_q   <= TGT_FTW;
            armed_q <= 1'b0;
            shadow  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            armed_q <= 1'b1;
            if (xfer && !load_abort) begin
                shadow <= {shadow[SHADOW_W-9:0], load_data};
            end
        end
    end

endmodule

// File: rtl/dds_phase_accum.sv
// DDS phase accumulator: FTW accumulation, phase-offset add and registered phase output to the sine stage.
module dds_phase_accum
    import dds_pkg::*;
#(
    parameter int ACC_W   = ACC_W_DEF,
    parameter int PHASE_W = PHASE_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               phase_sync,
    input  logic               load_valid,
    output logic               load_ready,
    input  logic [7:0]         load_data,
    input  logic               load_tgt,
    input  logic               load_abort,
    output logic [PHASE_W-1:0] phase,
    output logic               phase_valid,
    output logic               wrap
);

    logic [SHADOW_W-1:0] shadow;
    load_tgt_t           ld_tgt;
    load_state_t         ld_state;
    logic                commit;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    ftw;
    logic [PHASE_W-1:0]  poff;
    logic [ACC_W:0]      sum;
    logic                en_d1;

    dds_byte_loader u_loader (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_tgt   (load_tgt),
        .load_abort (load_abort),
        .shadow     (shadow),
        .tgt        (ld_tgt),
        .state      (ld_state)
    );

    assign commit = (ld_state == LD_COMMIT);
    assign sum    = {1'b0, acc} + {1'b0, ftw};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc         <= '0;
            ftw         <= '0;
            poff        <= '0;
            wrap        <= 1'b0;
            en_d1       <= 1'b0;
            phase       <= '0;
            phase_valid <= 1'b0;
        end else begin
            // The active word changes on the edge that ends COMMIT, so the next addition sees it.
            if (commit && (ld_tgt == TGT_FTW)) begin
                ftw <= shadow[ACC_W-1:0];
            end
            if (commit && (ld_tgt == TGT_POFF)) begin
                poff <= shadow[PHASE_W-1:0];
            end
            if (phase_sync) begin
                acc  <= '0;
                wrap <= 1'b0;
            end else if (en) begin
                acc  <= sum[ACC_W-1:0];
                wrap <= sum[ACC_W];
            end else begin
                wrap <= 1'b0;
            end
            phase       <= acc[ACC_W-1 -: PHASE_W] + poff;
            en_d1       <= en;
            phase_valid <= en_d1;
        end
    end

endmodule

// File: tb/tb_dds_phase_accum.sv
// Directed bench for dds_phase_accum: vector table for the pipeline plus hand-written load/sync/reset sequences.
module tb_dds_phase_accum;

    logic        clk;
    logic        rst;
    logic        en;
    logic        phase_sync;
    logic        load_valid;
    logic        load_ready;
    logic [7:0]  load_data;
    logic        load_tgt;
    logic        load_abort;
    logic [13:0] phase;
    logic        phase_valid;
    logic        wrap;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        en;
        logic        sync;
        logic [13:0] ph;
        logic        pv;
        logic        wr;
    } vec_t;

    vec_t vecs[10];

    dds_phase_accum u_dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .phase_sync  (phase_sync),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_data   (load_data),
        .load_tgt    (load_tgt),
        .load_abort  (load_abort),
        .phase       (phase),
        .phase_valid (phase_valid),
        .wrap        (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic t);
        chk("ready_before_byte", 32'(load_ready), 32'd1);
        load_valid = 1'b1;
        load_data  = d;
        load_tgt   = t;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic load3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_byte(b0, 1'b0);
        send_byte(b1, 1'b0);
        send_byte(b2, 1'b0);
        chk("ftw_ready_low_in_commit", 32'(load_ready), 32'd0);
        tick();
        chk("ftw_ready_after_commit", 32'(load_ready), 32'd1);
    endtask

    task automatic load2(input logic [7:0] b0, input logic [7:0] b1);
        send_byte(b0, 1'b1);
        send_byte(b1, 1'b1);
        chk("poff_ready_low_in_commit", 32'(load_ready), 32'd0);
        tick();
        chk("poff_ready_after_commit", 32'(load_ready), 32'd1);
    endtask

    // Clears acc, runs three enabled edges, and checks phase = top bits of (2*ftw) + poff.
    task automatic check_step(input string name, input logic [23:0] ftw_v, input logic [13:0] poff_v);
        logic [23:0] two;
        logic [13:0] exp_ph;
        two    = ftw_v + ftw_v;
        exp_ph = two[23:10] + poff_v;
        en         = 1'b0;
        phase_sync = 1'b1;
        tick();
        phase_sync = 1'b0;
        en         = 1'b1;
        tick();
        tick();
        tick();
        chk(name, 32'(phase), 32'(exp_ph));
        en = 1'b0;
    endtask

    initial begin
        int ph_err;
        int wraps;
        int first_wrap;
        int werr;

        // {en, sync, phase, phase_valid, wrap} with FTW=0x000400, POFF=0, acc=0 at entry
        vecs[0] = '{1'b1, 1'b0, 14'h0000, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 14'h0001, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 14'h0002, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 14'h0002, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 14'h0002, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 14'h0003, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 14'h0000, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 14'h0001, 1'b1, 1'b0};
        vecs[8] = '{1'b0, 1'b0, 14'h0002, 1'b1, 1'b0};
        vecs[9] = '{1'b0, 1'b0, 14'h0002, 1'b0, 1'b0};

        rst        = 1'b1;
        en         = 1'b0;
        phase_sync = 1'b0;
        load_valid = 1'b0;
        load_data  = 8'h00;
        load_tgt   = 1'b0;
        load_abort = 1'b0;

        // reset state
        tick();
        tick();
        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_phase_valid", 32'(phase_valid), 32'd0);
        chk("rst_wrap", 32'(wrap), 32'd0);
        chk("rst_load_ready", 32'(load_ready), 32'd0);
        rst = 1'b0;
        chk("ready_before_first_clock", 32'(load_ready), 32'd0);
        tick();
        chk("ready_first_clock", 32'(load_ready), 32'd1);

        // pipeline table with FTW=0x000400
        load3(8'h00, 8'h04, 8'h00);
        for (int i = 0; i < 10; i++) begin
            en         = vecs[i].en;
            phase_sync = vecs[i].sync;
            tick();
            chk($sformatf("vec%0d_phase", i), 32'(phase), 32'(vecs[i].ph));
            chk($sformatf("vec%0d_phase_valid", i), 32'(phase_valid), 32'(vecs[i].pv));
            chk($sformatf("vec%0d_wrap", i), 32'(wrap), 32'(vecs[i].wr));
        end
        phase_sync = 1'b0;

        // full ramp: +1 per cycle, wrap once per 16384 cycles
        en         = 1'b0;
        phase_sync = 1'b1;
        tick();
        phase_sync = 1'b0;
        en         = 1'b1;
        ph_err     = 0;
        wraps      = 0;
        first_wrap = -1;
        for (int k = 1; k <= 32768; k++) begin
            tick();
            if (phase !== 14'(k - 1)) ph_err++;
            if (wrap) begin
                wraps++;
                if (first_wrap < 0) first_wrap = k;
            end
        end
        chk("ramp_phase_errors", 32'(ph_err), 32'd0);
        chk("ramp_wrap_count", 32'(wraps), 32'd2);
        chk("ramp_first_wrap_cycle", 32'(first_wrap), 32'd16384);

        // FTW 0x123456 loaded while accumulating with 0x000400
        phase_sync = 1'b1;
        tick();
        phase_sync = 1'b0;
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'h56, 1'b0);
        chk("ftw123456_ready_commit", 32'(load_ready), 32'd0);
        chk("ftw123456_phase_b3", 32'(phase), 32'h0002);
        tick();
        chk("ftw123456_ready_after", 32'(load_ready), 32'd1);
        chk("ftw123456_phase_c", 32'(phase), 32'h0003);
        tick();
        chk("ftw123456_phase_n1", 32'(phase), 32'h0004);
        tick();
        chk("ftw123456_phase_n2", 32'(phase), 32'h0491);
        tick();
        chk("ftw123456_phase_n3", 32'(phase), 32'h091E);

        // FTW=0, POFF=0x1000: constant phase, valid follows en
        en = 1'b0;
        load3(8'h00, 8'h00, 8'h00);
        load2(8'h10, 8'h00);
        en         = 1'b1;
        phase_sync = 1'b1;
        tick();
        phase_sync = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ftw0_phase_const", 32'(phase), 32'h1000);
            chk("ftw0_phase_valid", 32'(phase_valid), 32'd1);
        end

        // phase_sync on the edge that would carry out: no wrap, phase = POFF
        load3(8'h00, 8'h04, 8'h00);
        werr = 0;
        for (int k = 1; k <= 16383; k++) begin
            tick();
            if (wrap) werr++;
        end
        chk("presync_no_wrap", 32'(werr), 32'd0);
        phase_sync = 1'b1;
        tick();
        phase_sync = 1'b0;
        chk("sync_wrap_suppressed", 32'(wrap), 32'd0);
        chk("sync_edge_phase", 32'(phase), 32'h0FFF);
        tick();
        chk("post_sync_phase_poff", 32'(phase), 32'h1000);
        chk("post_sync_wrap", 32'(wrap), 32'd0);

        // abort after two FTW bytes, then a full load with abort during COMMIT
        en = 1'b0;
        send_byte(8'h77, 1'b0);
        send_byte(8'h88, 1'b0);
        load_abort = 1'b1;
        tick();
        load_abort = 1'b0;
        chk("ready_after_abort", 32'(load_ready), 32'd1);
        check_step("ftw_kept_after_abort", 24'h000400, 14'h1000);
        send_byte(8'h00, 1'b0);
        send_byte(8'h08, 1'b0);
        send_byte(8'h00, 1'b0);
        chk("reload_ready_commit", 32'(load_ready), 32'd0);
        load_abort = 1'b1;
        tick();
        load_abort = 1'b0;
        chk("reload_ready_after", 32'(load_ready), 32'd1);
        check_step("ftw_commit_ignores_abort", 24'h000800, 14'h1000);

        // reset during the second byte of a load
        en = 1'b1;
        tick();
        tick();
        send_byte(8'h01, 1'b0);
        load_valid = 1'b1;
        load_data  = 8'h02;
        #2;
        rst = 1'b1;
        #1;
        chk("midload_rst_phase", 32'(phase), 32'd0);
        chk("midload_rst_phase_valid", 32'(phase_valid), 32'd0);
        chk("midload_rst_wrap", 32'(wrap), 32'd0);
        chk("midload_rst_load_ready", 32'(load_ready), 32'd0);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        load_valid = 1'b0;
        en         = 1'b0;
        chk("post_rst_ready_before_clock", 32'(load_ready), 32'd0);
        tick();
        chk("post_rst_ready_first_clock", 32'(load_ready), 32'd1);
        check_step("post_rst_ftw_zero", 24'h000000, 14'h0000);
        load3(8'h00, 8'h04, 8'h00);
        check_step("post_rst_full_load", 24'h000400, 14'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dds_phase_accum.md
DDS_PHASE_ACCUM -- requirements
Module: dds_phase_accum

Interface
REQ-001 The block SHALL have parameter ACC_W, default 24, meaning accumulator width in bits.
REQ-002 The block SHALL have parameter PHASE_W, default 14, meaning output phase width, matching the sine LUT phase input.
REQ-003 Port clk  in  1  sole clock, all state on rising edge.
REQ-004 Port rst  in  1  reset, asynchronous, active-high.
REQ-005 Port en  in  1  accumulate enable.
REQ-006 Port phase_sync  in  1  clear accumulator to zero.
REQ-007 Port load_valid  in  1  load byte present.
REQ-008 Port load_ready  out  1  block accepts load byte.
REQ-009 Port load_data  in  8  load byte, MSB-first.
REQ-010 Port load_tgt  in  1  target: 0 = FTW (tuning word), 1 = POFF (phase offset); sampled on first byte only.
REQ-011 Port load_abort  in  1  discard partial load.
REQ-012 Port phase  out  PHASE_W  registered phase to sine stage.
REQ-013 Port phase_valid  out  1  phase qualifies a new sample.
REQ-014 Port wrap  out  1  one-cycle pulse on accumulator carry-out.

Function
REQ-015 Byte transfer SHALL occur only in a cycle with load_valid=1 and load_ready=1.
REQ-016 Loader FSM states SHALL be IDLE, BYTE, COMMIT; IDLE->BYTE on first transfer; BYTE->COMMIT on last transfer; COMMIT->IDLE unconditionally after one cycle.
REQ-017 FTW load SHALL take 3 bytes into a shadow register; POFF load SHALL take 2 bytes, with the low PHASE_W bits of the 16 used.
REQ-018 load_ready SHALL be 1 in IDLE and BYTE, and 0 in COMMIT and during reset.
REQ-019 In COMMIT the shadow SHALL be copied atomically to the active FTW or POFF; the new value SHALL take effect on the accumulation in the cycle after COMMIT.
REQ-020 load_abort=1 SHALL force IDLE next cycle and leave the active FTW/POFF unchanged; abort in COMMIT SHALL be ignored, and the commit completes.
REQ-021 When en=1, acc SHALL become (acc + FTW) mod 2^ACC_W each cycle; when en=0, acc SHALL hold.
REQ-022 wrap SHALL be 1 for the cycle after an addition whose carry-out is 1, and 0 otherwise.
REQ-023 phase SHALL become (acc[ACC_W-1:ACC_W-PHASE_W] + POFF) mod 2^PHASE_W, registered, one cycle after acc.
REQ-024 phase_valid SHALL equal en delayed by two cycles, aligned with phase.
REQ-025 phase_sync=1 SHALL set acc to 0 next cycle regardless of en, suppress wrap for that cycle, and not affect the loader or the active FTW/POFF.
REQ-026 A commit coinciding with phase_sync SHALL both apply the new value and clear acc.
REQ-027 FTW=0 SHALL hold phase constant at truncated acc + POFF, with phase_valid still following en.

Reset
REQ-028 While rst=1: acc, FTW, POFF, shadow, phase, phase_valid, wrap and load_ready SHALL be 0, and the FSM SHALL be in IDLE.
REQ-029 Reset asserted mid-load SHALL discard the partial load; load_ready SHALL go 1 on the first clock after rst deasserts.

Structure
REQ-030 Package dds_pkg SHALL hold ACC_W/PHASE_W defaults, FTW_BYTES=3, POFF_BYTES=2, the loader state enum, and the target encoding.
REQ-031 The loader FSM, shadow register and byte counter SHALL be a sub-module dds_byte_loader; accumulation and phase output SHALL remain in the top.

Verification
REQ-032 Load FTW 0x000400, en=1 -> phase steps +1 per cycle, wraps 0x3FFF->0x0000, and wrap pulses once per 16384 cycles.
REQ-033 Send bytes 0x12,0x34,0x56 with tgt=0 -> active FTW=0x123456; load_ready is 0 for exactly the COMMIT cycle; the new step size is seen 1 cycle later.
REQ-034 FTW=0 with POFF bytes 0x10,0x00 -> phase=0x1000 constant and phase_valid=1.
REQ-035 Assert phase_sync while en=1 and FTW=0x000400 -> acc=0 next cycle, phase=POFF one cycle after, and no wrap pulse.
REQ-036 Abort after 2 FTW bytes -> FTW unchanged and FSM in IDLE; the next full 3-byte load succeeds.
REQ-037 Assert rst during the second byte of a load -> all outputs 0; after release, FTW=0 and load_ready=1 after one clock.
